// File: rtl/prog_counter_core_if.sv
// Control and status bundle of the programmable counter core.
// The master side drives the controls and the slave side is the counter.
interface prog_counter_core_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             match;

    modport master (
        output en, load, load_val, dir, mode, limit, cmp_val,
        input  count, tc, done, match
    );

    modport slave (
        input  en, load, load_val, dir, mode, limit, cmp_val,
        output count, tc, done, match
    );
endinterface

// File: rtl/prog_counter_core.sv
// Programmable up/down counter over [0, limit] with wrap or one-shot behaviour,
// a synchronous load, a one-cycle terminal-count pulse and a compare-match flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | counting; each enabled edge takes one step
// ST_HALT | one-shot reached its terminal event; count frozen until load/rst
module prog_counter_core #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    prog_counter_core_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             terminal;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        done_d   = done_q;
        terminal = 1'b0;

        if (bus.load) begin
            count_d = bus.load_val;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (bus.en && (state_q == ST_RUN)) begin
            // A count above limit is terminal going up but decrements normally going down.
            if (bus.dir) begin
                if (count_q < bus.limit) begin
                    count_d = count_q + 1'b1;
                end else begin
                    terminal = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    terminal = 1'b1;
                end
            end

            if (terminal) begin
                tc_d = 1'b1;
                if (bus.mode) begin
                    done_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    count_d = bus.dir ? '0 : bus.limit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= RESET_VALUE;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;
    assign bus.match = (count_q == bus.cmp_val);
endmodule
